// File: rtl/pipe_core_fwd_if.sv
// Core-side bus of pipe_core_fwd: run control, IMEM load port, register debug
// read and the retire/halt status.
interface pipe_core_fwd_if #(
  parameter int DATA_W     = 8,
  parameter int NREG       = 8,
  parameter int IMEM_DEPTH = 16
);
  localparam int RW = $clog2(NREG);
  localparam int IW = $clog2(IMEM_DEPTH);

  logic              run;
  logic              imem_we;
  logic [IW-1:0]     imem_addr;
  logic [15:0]       imem_wdata;
  logic [RW-1:0]     dbg_raddr;
  logic [DATA_W-1:0] dbg_rdata;
  logic              retire_valid;
  logic [RW-1:0]     retire_rd;
  logic [DATA_W-1:0] retire_data;
  logic              halted;

  modport master (
    output run, imem_we, imem_addr, imem_wdata, dbg_raddr,
    input  dbg_rdata, retire_valid, retire_rd, retire_data, halted
  );

  modport slave (
    input  run, imem_we, imem_addr, imem_wdata, dbg_raddr,
    output dbg_rdata, retire_valid, retire_rd, retire_data, halted
  );
endinterface

// File: rtl/pipe_core_fwd.sv
// 5-stage in-order core (IF/ID/EX/MEM/WB) for the 16-bit ISA with EX/MEM and
// MEM/WB forwarding, a one-cycle load-use interlock and HALT.
module pipe_core_fwd #(
  parameter int DATA_W     = 8,
  parameter int NREG       = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  pipe_core_fwd_if.slave bus
);
  localparam int RW = $clog2(NREG);
  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_LOAD = 4'h4;
  localparam logic [3:0] OP_STOR = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    logic [3:0]    op;
    logic [RW-1:0] rd;
    logic [RW-1:0] src1;
    logic [RW-1:0] src2;   // rs2, or rd for STORE (store data operand)
    word_t         a;
    word_t         b;
    word_t         imm;
  } id_ex_t;

  typedef struct packed {
    logic [3:0]    op;
    logic [RW-1:0] rd;
    word_t         res;    // ALU result or effective address
    word_t         sdata;
  } ex_mem_t;

  typedef struct packed {
    logic [3:0]    op;
    logic [RW-1:0] rd;
    word_t         data;
  } mem_wb_t;

  logic [IMEM_DEPTH-1:0][15:0]     imem;
  logic [NREG-1:0][DATA_W-1:0]     regs;
  logic [DMEM_DEPTH-1:0][DATA_W-1:0] dmem;

  logic [IW-1:0] pc;
  logic [15:0]   if_id;
  logic          halt_seen;
  id_ex_t        id_ex;
  ex_mem_t       ex_mem;
  mem_wb_t       mem_wb;
  logic [3:1]    vld_pipe;   // register-write valid for ID/EX, EX/MEM, MEM/WB
  logic          halted_q;

  logic [3:0]    op;
  logic [RW-1:0] rd_i, rs1_i, src2_i;
  word_t         imm_i, rf_a, rf_b;
  logic          use1, use2, id_wen, stall, halt_id, fetch_en;
  word_t         fa, fb, alu;
  logic [DW-1:0] ea;
  word_t         wb_data;
  logic          unused;

  // ID decode, hazard detection and fetch enable
  always_comb begin
    op       = if_id[15:12];
    rd_i     = if_id[8 +: RW];
    rs1_i    = if_id[4 +: RW];
    imm_i    = word_t'(if_id[3:0]);
    src2_i   = (op == OP_STOR) ? rd_i : if_id[0 +: RW];
    use1     = op inside {OP_ADD, OP_SUB, OP_AND, OP_LOAD, OP_STOR, OP_ADDI};
    use2     = op inside {OP_ADD, OP_SUB, OP_AND, OP_STOR};
    id_wen   = (op inside {OP_ADD, OP_SUB, OP_AND, OP_LOAD, OP_ADDI}) && (rd_i != '0);
    stall    = (id_ex.op == OP_LOAD) && vld_pipe[1] &&
               ((use1 && rs1_i == id_ex.rd) || (use2 && src2_i == id_ex.rd));
    halt_id  = (op == OP_HALT);
    fetch_en = bus.run && !halt_seen && !halt_id && !stall;
  end

  assign unused = ^{if_id[11:8], if_id[7:4]};

  // register file read, write-through from the instruction in WB
  always_comb begin
    rf_a = '0;
    rf_b = '0;
    if (rs1_i != '0)
      rf_a = (vld_pipe[3] && mem_wb.rd == rs1_i) ? mem_wb.data : regs[rs1_i];
    if (src2_i != '0)
      rf_b = (vld_pipe[3] && mem_wb.rd == src2_i) ? mem_wb.data : regs[src2_i];
  end

  // EX operand forwarding (EX/MEM beats MEM/WB) and ALU
  always_comb begin
    fa = id_ex.a;
    fb = id_ex.b;
    if (vld_pipe[3] && mem_wb.rd == id_ex.src1) fa = mem_wb.data;
    if (vld_pipe[3] && mem_wb.rd == id_ex.src2) fb = mem_wb.data;
    // a LOAD in MEM has no value yet; the interlock keeps its consumer out of EX
    if (vld_pipe[2] && ex_mem.op != OP_LOAD && ex_mem.rd == id_ex.src1) fa = ex_mem.res;
    if (vld_pipe[2] && ex_mem.op != OP_LOAD && ex_mem.rd == id_ex.src2) fb = ex_mem.res;
    case (id_ex.op)
      OP_ADD:                    alu = fa + fb;
      OP_SUB:                    alu = fa - fb;
      OP_AND:                    alu = fa & fb;
      OP_LOAD, OP_STOR, OP_ADDI: alu = fa + id_ex.imm;
      default:                   alu = '0;
    endcase
  end

  // MEM stage data select
  always_comb begin
    ea      = ex_mem.res[DW-1:0];
    wb_data = (ex_mem.op == OP_LOAD) ? dmem[ea] : ex_mem.res;
  end

  // IMEM load port; contents survive reset, a same-cycle fetch sees the old word
  always_ff @(posedge clk) begin
    if (bus.imem_we) imem[bus.imem_addr] <= bus.imem_wdata;
  end

  // fetch: PC, IF/ID and the HALT fetch-stop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      if_id     <= '0;
      halt_seen <= 1'b0;
    end else begin
      if (halt_id) halt_seen <= 1'b1;
      if (!stall) if_id <= fetch_en ? imem[pc] : 16'h0000;
      if (fetch_en) pc <= pc + IW'(1);
    end
  end

  // ID/EX, EX/MEM, MEM/WB pipeline registers and sticky halt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex    <= '0;
      ex_mem   <= '0;
      mem_wb   <= '0;
      vld_pipe <= '0;
      halted_q <= 1'b0;
    end else begin
      if (stall) id_ex <= '0;
      else       id_ex <= '{op: op, rd: rd_i, src1: rs1_i, src2: src2_i,
                            a: rf_a, b: rf_b, imm: imm_i};
      ex_mem   <= '{op: id_ex.op, rd: id_ex.rd, res: alu, sdata: fb};
      mem_wb   <= '{op: ex_mem.op, rd: ex_mem.rd, data: wb_data};
      vld_pipe <= {vld_pipe[2:1], id_wen && !stall};
      if (mem_wb.op == OP_HALT) halted_q <= 1'b1;
    end
  end

  // register file write from WB
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            regs <= '0;
    else if (vld_pipe[3]) regs[mem_wb.rd] <= mem_wb.data;
  end

  // data memory write from MEM
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      dmem <= '0;
    else if (ex_mem.op == OP_STOR)  dmem[ea] <= ex_mem.sdata;
  end

  assign bus.retire_valid = vld_pipe[3];
  assign bus.retire_rd    = vld_pipe[3] ? mem_wb.rd : '0;
  assign bus.retire_data  = vld_pipe[3] ? mem_wb.data : '0;
  assign bus.halted       = halted_q;
  assign bus.dbg_rdata    = regs[bus.dbg_raddr];
endmodule

// File: tb/tb_pipe_core_fwd.sv
// Directed bench for pipe_core_fwd: retire scoreboard plus timing and register checks.
module tb_pipe_core_fwd;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_core_fwd_if bus ();
  pipe_core_fwd u_dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start = 0;
  int halt_cyc = -1;
  logic halt_q = 1'b0;

  typedef struct { logic [2:0] rd; logic [7:0] data; } ret_t;
  ret_t sb[$];
  int   ret_cyc[$];
  ret_t e;
  logic [7:0] rv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // retire monitor: every retire must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.halted && !halt_q) halt_cyc = cyc;
    halt_q = bus.halted;
    if (bus.retire_valid) begin
      ret_cyc.push_back(cyc);
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL retire_unexpected observed=r%0d:%0h expected=none", bus.retire_rd, bus.retire_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        total++;
        assert (bus.retire_rd === e.rd && bus.retire_data === e.data) else begin
          bad++;
          $error("FAIL retire observed=r%0d:%0h expected=r%0d:%0h",
                 bus.retire_rd, bus.retire_data, e.rd, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ret(input int rd, input int data);
    ret_t r;
    r.rd = 3'(rd);
    r.data = 8'(data);
    sb.push_back(r);
  endtask

  task automatic rdreg(input int idx, output logic [7:0] v);
    bus.dbg_raddr = 3'(idx);
    #1;
    v = bus.dbg_rdata;
  endtask

  task automatic load(input logic [15:0] w0, w1, w2, w3, w4);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) begin
      case (i)
        0: w = w0; 1: w = w1; 2: w = w2; 3: w = w3; 4: w = w4;
        default: w = 16'h0000;
      endcase
      bus.imem_we = 1'b1;
      bus.imem_addr = 4'(i);
      bus.imem_wdata = w;
      tick();
    end
    bus.imem_we = 1'b0;
  endtask

  task automatic do_reset();
    bus.run = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    ret_cyc.delete();
    halt_cyc = -1;
  endtask

  task automatic run_prog(input int n);
    ret_cyc.delete();
    start = cyc;
    bus.run = 1'b1;
    repeat (n) tick();
    bus.run = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test2_checks(input string t);
    chk({t, "_sb_empty"}, sb.size(), 0);
    chk({t, "_nret"}, ret_cyc.size(), 3);
    chk({t, "_addi_cyc"}, ret_cyc[0], start + 4);
    chk({t, "_load_cyc"}, ret_cyc[1], start + 6);
    chk({t, "_add_cyc_bubble"}, ret_cyc[2], start + 8);
    rdreg(4, rv); chk({t, "_r4"}, rv, 8'd9);
    rdreg(5, rv); chk({t, "_r5"}, rv, 8'd18);
  endtask

  initial begin
    reset = 1'b1;
    bus.run = 1'b0;
    bus.imem_we = 1'b0;
    bus.imem_addr = '0;
    bus.imem_wdata = '0;
    bus.dbg_raddr = '0;
    tick();
    tick();
    chk("rst_retire_valid", bus.retire_valid, 1'b0);
    chk("rst_retire_rd", bus.retire_rd, 3'd0);
    chk("rst_retire_data", bus.retire_data, 8'd0);
    chk("rst_halted", bus.halted, 1'b0);
    rdreg(1, rv); chk("rst_r1", rv, 8'd0);
    reset = 1'b0;

    // 1: back-to-back dependencies via forwarding
    load(16'h6105, 16'h1211, 16'h2321, 16'h0000, 16'h0000);
    do_reset();
    expect_ret(1, 5); expect_ret(2, 10); expect_ret(3, 5);
    run_prog(6);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_nret", ret_cyc.size(), 3);
    chk("t1_lat", ret_cyc[0], start + 4);
    chk("t1_cyc1", ret_cyc[1], start + 5);
    chk("t1_cyc2", ret_cyc[2], start + 6);
    rdreg(2, rv); chk("t1_r2", rv, 8'd10);
    rdreg(3, rv); chk("t1_r3", rv, 8'd5);

    // 2: store, load, load-use bubble
    load(16'h6109, 16'h5102, 16'h4402, 16'h1544, 16'h0000);
    do_reset();
    expect_ret(1, 9); expect_ret(4, 9); expect_ret(5, 18);
    run_prog(6);
    test2_checks("t2");

    // 3: modulo wrap of arithmetic
    load(16'h6101, 16'h2201, 16'h6221, 16'h0000, 16'h0000);
    do_reset();
    expect_ret(1, 1); expect_ret(2, 8'hFF); expect_ret(2, 0);
    run_prog(6);
    chk("t3_sb_empty", sb.size(), 0);
    rdreg(2, rv); chk("t3_r2", rv, 8'd0);

    // 4: r0 writes discarded, r0 reads zero
    load(16'h6007, 16'h1600, 16'h0000, 16'h0000, 16'h0000);
    do_reset();
    expect_ret(6, 0);
    run_prog(6);
    chk("t4_sb_empty", sb.size(), 0);
    chk("t4_nret", ret_cyc.size(), 1);
    rdreg(0, rv); chk("t4_r0", rv, 8'd0);
    rdreg(6, rv); chk("t4_r6", rv, 8'd0);

    // 5: HALT at address 3, later instruction never executes
    load(16'h6103, 16'h6204, 16'h1312, 16'hF000, 16'h6401);
    do_reset();
    expect_ret(1, 3); expect_ret(2, 4); expect_ret(3, 7);
    run_prog(8);
    chk("t5_halt_cyc", halt_cyc, start + 8);
    for (int i = 0; i < 4; i++) begin
      bus.run = i[0];
      tick();
      tick();
    end
    bus.run = 1'b0;
    chk("t5_halted", bus.halted, 1'b1);
    chk("t5_sb_empty", sb.size(), 0);
    chk("t5_nret", ret_cyc.size(), 3);
    rdreg(3, rv); chk("t5_r3", rv, 8'd7);
    rdreg(4, rv); chk("t5_r4", rv, 8'd0);

    // 6: asynchronous reset in the middle of program 2, then rerun
    load(16'h6109, 16'h5102, 16'h4402, 16'h1544, 16'h0000);
    do_reset();
    expect_ret(1, 9);
    start = cyc;
    bus.run = 1'b1;
    repeat (5) tick();
    #1;
    reset = 1'b1;
    bus.run = 1'b0;
    #1;
    chk("t6_async_valid", bus.retire_valid, 1'b0);
    chk("t6_async_rd", bus.retire_rd, 3'd0);
    chk("t6_async_data", bus.retire_data, 8'd0);
    chk("t6_async_halted", bus.halted, 1'b0);
    rdreg(1, rv); chk("t6_async_r1", rv, 8'd0);
    tick();
    tick();
    reset = 1'b0;
    chk("t6_pre_sb_empty", sb.size(), 0);
    expect_ret(1, 9); expect_ret(4, 9); expect_ret(5, 18);
    run_prog(6);
    test2_checks("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
